// File: rtl/noc_pio_input_capture.sv
// noc_pio_input_capture
//
// Avalon-MM input PIO with a synchroniser, per-bit edge capture, a per-bit
// interrupt mask and a level-sensitive interrupt.
//
// Register map (word address):
//   0 data        RO  synchronised in_port
//   1 irqmask     RW  DATA_WIDTH bits
//   2 reserved    reads 0, writes ignored
//   3 edgecapture R, write clears (see NOC_PIO_BIT_CLEAR_EN)
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata    Avalon-MM slave write/address side
//   in_port               asynchronous external input bus
//   readdata              registered read data, 1-cycle latency, zero-extended
//   irq                   OR of (edgecapture & irqmask), active high
//
// Build option:
//   NOC_PIO_BIT_CLEAR_EN  defined: a write to address 3 clears only the bits set
//                         in writedata. Undefined: any such write clears all bits.

module noc_pio_input_capture #(
  parameter int unsigned DATA_WIDTH  = 8,  // 1..32
  parameter int unsigned SYNC_STAGES = 2,  // 1..4
  parameter int unsigned EDGE_TYPE   = 0   // 0 rising, 1 falling, 2 any
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam int unsigned ChainW = SYNC_STAGES * DATA_WIDTH;

  // Stage 0 occupies the low DATA_WIDTH bits; the last stage is at the top.
  logic [ChainW-1:0]     chain_q, chain_d;
  logic [DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d;
  logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
  logic [DATA_WIDTH-1:0] clear_bits;
  logic [31:0]           readdata_q, readdata_d;
  logic                  wr_en;

  generate
    if (SYNC_STAGES == 1) begin : g_sync_one
      assign chain_d = in_port;
    end else begin : g_sync_multi
      assign chain_d = {chain_q[ChainW-DATA_WIDTH-1:0], in_port};
    end
  endgenerate

  assign sync_q = chain_q[ChainW-1 -: DATA_WIDTH];
  assign wr_en  = chipselect & ~write_n;

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = sync_q & ~prev_q;
      1:       edge_det = ~sync_q & prev_q;
      default: edge_det = sync_q ^ prev_q;
    endcase
  end

  always_comb begin
    clear_bits = '0;
    if (wr_en && address == 2'd3) begin
`ifdef NOC_PIO_BIT_CLEAR_EN
      clear_bits = writedata[DATA_WIDTH-1:0];
`else
      clear_bits = '1;
`endif
    end
  end

  // Clear first, then OR in new edges so a same-cycle edge wins.
  assign edgecap_d = (edgecap_q & ~clear_bits) | edge_det;

  always_comb begin
    irqmask_d = irqmask_q;
    if (wr_en && address == 2'd1) begin
      irqmask_d = writedata[DATA_WIDTH-1:0];
    end
  end

  // Reads see pre-update register contents, no chipselect gating.
  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[DATA_WIDTH-1:0] = sync_q;
      2'd1:    readdata_d[DATA_WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[DATA_WIDTH-1:0] = edgecap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q    <= '0;
      prev_q     <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      chain_q    <= chain_d;
      prev_q     <= sync_q;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

  // Bits of writedata above DATA_WIDTH are intentionally ignored.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

endmodule

// File: tb/tb_noc_pio_input_capture.sv
// Testbench for noc_pio_input_capture with default parameters
// (DATA_WIDTH=8, SYNC_STAGES=2, EDGE_TYPE=0). Expected clear behaviour follows
// whether NOC_PIO_BIT_CLEAR_EN is defined for the build.

module tb_noc_pio_input_capture;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_checks;
  int n_errors;

  logic [31:0] exp_q[$];
  string       name_q[$];

  noc_pio_input_capture #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2),
    .EDGE_TYPE  (0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  in_val;
    logic [7:0]  mask;
    logic [31:0] exp_cap;
    logic        exp_irq;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Expected read value is queued at address drive and compared when readdata lands.
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] e;
    string       n;
    address = a;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    tick();
    e = exp_q.pop_front();
    n = name_q.pop_front();
    chk(n, readdata, e);
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  vec_t vecs[6];

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'h00;

    vecs[0] = '{in_val: 8'hA5, mask: 8'h00, exp_cap: 32'h000000A5, exp_irq: 1'b0};
    vecs[1] = '{in_val: 8'h5A, mask: 8'h0F, exp_cap: 32'h0000005A, exp_irq: 1'b1};
    vecs[2] = '{in_val: 8'hFF, mask: 8'hA0, exp_cap: 32'h000000A5, exp_irq: 1'b1};
    vecs[3] = '{in_val: 8'h00, mask: 8'hFF, exp_cap: 32'h00000000, exp_irq: 1'b0};
    vecs[4] = '{in_val: 8'h81, mask: 8'h7E, exp_cap: 32'h00000081, exp_irq: 1'b0};
    vecs[5] = '{in_val: 8'h3C, mask: 8'h04, exp_cap: 32'h0000003C, exp_irq: 1'b1};

    // Reset, then read every address.
    repeat (3) tick();
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_readdata", readdata, 32'd0);
    reset_n = 1'b1;
    tick();
    rd(2'd0, 32'd0, "rst_rd_data");
    rd(2'd1, 32'd0, "rst_rd_mask");
    rd(2'd2, 32'd0, "rst_rd_rsvd");
    rd(2'd3, 32'd0, "rst_rd_cap");
    chk("rst_irq_after", {31'd0, irq}, 32'd0);

    // Table: clear, change input, set mask, let it settle, check capture.
    for (int i = 0; i < 6; i++) begin
      wr(2'd3, 32'hFF);
      in_port = vecs[i].in_val;
      wr(2'd1, {24'd0, vecs[i].mask});
      repeat (3) tick();
      rd(2'd0, {24'd0, vecs[i].in_val}, $sformatf("vec%0d_data", i));
      rd(2'd1, {24'd0, vecs[i].mask}, $sformatf("vec%0d_mask", i));
      rd(2'd3, vecs[i].exp_cap, $sformatf("vec%0d_cap", i));
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
    end

    // Reserved address ignores writes.
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, 32'd0, "rsvd_after_write");

    // Data-path and capture latency with in_port 0x3C -> 0xA5.
    wr(2'd1, 32'hFF);
    wr(2'd3, 32'hFF);
    chk("lat_irq_cleared", {31'd0, irq}, 32'd0);
    address = 2'd0;
    tick();
    in_port = 8'hA5;
    exp_q.push_back(32'h3C); name_q.push_back("lat_e0");
    tick();
    chk(name_q.pop_front(), readdata, exp_q.pop_front());
    exp_q.push_back(32'h3C); name_q.push_back("lat_e1");
    tick();
    chk(name_q.pop_front(), readdata, exp_q.pop_front());
    chk("lat_irq_e1", {31'd0, irq}, 32'd0);
    exp_q.push_back(32'hA5); name_q.push_back("lat_e2");
    tick();
    chk(name_q.pop_front(), readdata, exp_q.pop_front());
    chk("lat_irq_e2", {31'd0, irq}, 32'd1);
    rd(2'd3, 32'h81, "lat_cap");

    // Rising only: falling edges are not captured.
    wr(2'd1, 32'h01);
    wr(2'd3, 32'hFF);
    in_port = 8'h00;
    settle();
    rd(2'd3, 32'h00, "fall_ignored");
    in_port = 8'h01;
    settle();
    rd(2'd3, 32'h01, "rise_bit0");
    chk("rise_bit0_irq", {31'd0, irq}, 32'd1);
    in_port = 8'h00;
    settle();
    rd(2'd3, 32'h01, "sticky_bit0");
    chk("sticky_irq", {31'd0, irq}, 32'd1);

    // Masking.
    wr(2'd3, 32'hFF);
    chk("clear_drops_irq", {31'd0, irq}, 32'd0);
    in_port = 8'h08;
    settle();
    rd(2'd3, 32'h08, "bit3_cap");
    chk("bit3_masked_irq", {31'd0, irq}, 32'd0);
    wr(2'd1, 32'h09);
    chk("mask_write_irq", {31'd0, irq}, 32'd1);

    // Partial clear vs clear-all.
    in_port = 8'h09;
    settle();
    rd(2'd3, 32'h09, "cap_09");
    wr(2'd3, 32'h01);
`ifdef NOC_PIO_BIT_CLEAR_EN
    rd(2'd3, 32'h08, "bit_clear");
    chk("bit_clear_irq", {31'd0, irq}, 32'd1);
`else
    rd(2'd3, 32'h00, "clear_all");
    chk("clear_all_irq", {31'd0, irq}, 32'd0);
`endif

    // Set wins: bit0 rises so its capture edge coincides with a clear write.
    in_port = 8'h08;
    settle();
    wr(2'd3, 32'hFF);
    rd(2'd3, 32'h00, "collide_pre");
    in_port = 8'h09;
    tick();
    tick();
    wr(2'd3, 32'h01);
    rd(2'd3, 32'h01, "collide_set_wins");
    chk("collide_irq", {31'd0, irq}, 32'd1);

    // Mid-operation reset: irq drops immediately, steady-high input recaptures.
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    tick();
    reset_n = 1'b1;
    rd(2'd1, 32'h00, "midrst_mask");
    settle();
    rd(2'd3, 32'h09, "midrst_recapture");
    chk("midrst_irq_masked", {31'd0, irq}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/noc_pio_input_capture.md
Name: noc_pio_input_capture

Overview:
Parametrised successor to the single-register NoC input PIO: an Avalon-MM slave that samples a DATA_WIDTH-bit external input bus through a synchroniser. Adds per-bit edge capture, a per-bit interrupt mask and a level-sensitive interrupt output. Sits between NoC/fabric status lines and the Nios II data master, so software can poll or take interrupts on input changes.

Parameters:
DATA_WIDTH, 8, width of in_port and of all per-bit registers; legal range 1..32
SYNC_STAGES, 2, flops in the input synchroniser chain; legal range 1..4
EDGE_TYPE, 0, edge that sets a capture bit: 0 rising, 1 falling, 2 any

Ports:
clk  input  1  system clock; all state on its rising edge
reset_n  input  1  asynchronous, active-low reset
address  input  2  word address of the register being accessed
chipselect  input  1  slave selected
write_n  input  1  active-low write strobe; qualified by chipselect
writedata  input  32  write data; bits above DATA_WIDTH ignored
in_port  input  DATA_WIDTH  asynchronous external input bus
readdata  output  32  registered read data; zero-extended above DATA_WIDTH
irq  output  1  interrupt request, active high, level

Behaviour:
- Reset (asynchronous assert, clk-synchronous release): synchroniser chain, delay register, irqmask, edgecapture and readdata all 0. irq is 0.
- Synchroniser: in_port passes through SYNC_STAGES flops. sync_q is the last stage.
- Latency: a value on in_port stable before edge E0 appears on sync_q after edge E0+SYNC_STAGES-1.
- Edge detect: prev_q takes sync_q every cycle.
  - Rising: sync_q & ~prev_q. Falling: ~sync_q & prev_q. Any: sync_q ^ prev_q.
  - An edge sets its edgecapture bit at the next clock edge, i.e. after E0+SYNC_STAGES.
  - Because prev_q resets to 0, a steady high input after reset produces one rising capture.
- Register map:
  - 0: data, read-only, returns sync_q. Writes are ignored.
  - 1: irqmask, read/write, DATA_WIDTH bits.
  - 2: reserved, reads 0, writes ignored.
  - 3: edgecapture, read; write clears bits (see Optional Feature).
- Write: occurs on the clock edge where chipselect=1 and write_n=0.
- Read: readdata updates every clock from the current address, with no chipselect gating. Read latency is 1 cycle.
  - readdata shows the register contents as they were before any same-edge update.
- Simultaneous clear and new edge on the same bit in the same cycle: set wins, and the bit stays 1.
- Sticky capture: edgecapture bits remain set until cleared by software. Further edges on a set bit have no additional effect.
- irq = OR over bits of (edgecapture & irqmask). It is combinational from registers and has no extra latency.
  - irq deasserts in the cycle after the clearing write or the mask write.
- No counters wrap. DATA_WIDTH=32 leaves no zero-extension; DATA_WIDTH=1 uses bit 0 only.
- Reset mid-operation: all captured edges and masks are lost. irq drops immediately on reset assertion.

Optional Feature:
Macro NOC_PIO_BIT_CLEAR_EN.
- Defined: a write to address 3 clears only the edgecapture bits where writedata bit is 1. Other bits are preserved.
- Undefined: any write to address 3 clears all edgecapture bits, regardless of writedata.
- Set-wins-over-clear applies in both builds.

Test Plan:
1. Reset then read: reset_n low 3 cycles, in_port=0x00, read addresses 0..3 -> readdata=0 for each, irq=0.
2. Data path latency (SYNC_STAGES=2): in_port 0x00->0xA5 before edge E0, address=0 -> sync_q=0xA5 after E0+1, readdata=0x000000A5 after E0+2, upper 24 bits zero.
3. Rising capture and irq (EDGE_TYPE=0): write irqmask=0x01, toggle in_port bit0 0->1 -> edgecapture=0x01 after E0+2, irq=1. Falling edge on bit0 -> no further change.
4. Masking: edge on bit3 with irqmask=0x01 -> edgecapture=0x08, irq=0. Write irqmask=0x09 -> irq=1 the next cycle.
5. Clear: edgecapture=0x09. With NOC_PIO_BIT_CLEAR_EN, write 0x01 to address 3 -> edgecapture=0x08. Without the macro, same write -> 0x00.
6. Set-wins collision: bit0 edge detected in the same cycle as a clear write of 0x01 -> edgecapture bit0 remains 1, irq stays asserted when masked. With EDGE_TYPE=2, both edges capture.
